// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32 decode stage with a 2-entry skid buffer so that
//            in_ready comes straight from a flop.
// Revision : 1.0
// ============================================================================
module decode_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SUPPORT_M   = 1,
    parameter int unsigned SUPPORT_A   = 1,
    parameter int unsigned SUPPORT_CSR = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [31:0]     out_imm,
    output logic [3:0]      out_class,
    output logic            out_illegal,
    output logic            out_uses_rs1,
    output logic            out_uses_rs2,
    output logic            out_writes_rd
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_AMO      = 7'b0101111;

    localparam logic [3:0] C_ALU_REG = 4'd0;
    localparam logic [3:0] C_ALU_IMM = 4'd1;
    localparam logic [3:0] C_LOAD    = 4'd2;
    localparam logic [3:0] C_STORE   = 4'd3;
    localparam logic [3:0] C_BRANCH  = 4'd4;
    localparam logic [3:0] C_JAL     = 4'd5;
    localparam logic [3:0] C_JALR    = 4'd6;
    localparam logic [3:0] C_LUI     = 4'd7;
    localparam logic [3:0] C_AUIPC   = 4'd8;
    localparam logic [3:0] C_MUL     = 4'd9;
    localparam logic [3:0] C_DIV     = 4'd10;
    localparam logic [3:0] C_AMO     = 4'd11;
    localparam logic [3:0] C_CSR     = 4'd12;
    localparam logic [3:0] C_ENV     = 4'd13;
    localparam logic [3:0] C_FENCE   = 4'd14;
    localparam logic [3:0] C_ILLEGAL = 4'd15;

    localparam logic [4:0] F5_LR = 5'b00010;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [31:0]     imm;
        logic [3:0]      iclass;
        logic            illegal;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
    } entry_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  funct5;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        amo_f5_ok;
    logic        env_exact;

    logic [3:0]  cls;
    logic [31:0] imm;
    logic        use1, use2, wr;
    entry_t      dec;

    entry_t      main_q, main_d, skid_q, skid_d;
    logic        main_valid_q, main_valid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign funct5 = in_instr[31:27];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

    // ECALL, EBREAK, MRET, WFI are the only funct3=000 SYSTEM words accepted
    assign env_exact = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073) ||
                       (in_instr == 32'h3020_0073) || (in_instr == 32'h1050_0073);

    always_comb begin
        amo_f5_ok = 1'b0;
        case (funct5)
            5'b00010, 5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
            5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100: amo_f5_ok = 1'b1;
            default: amo_f5_ok = 1'b0;
        endcase
    end

    always_comb begin
        cls  = C_ILLEGAL;
        imm  = '0;
        use1 = 1'b0;
        use2 = 1'b0;
        wr   = 1'b0;
        case (opcode)
            OPC_LUI:   begin cls = C_LUI;   imm = imm_u; wr = 1'b1; end
            OPC_AUIPC: begin cls = C_AUIPC; imm = imm_u; wr = 1'b1; end
            OPC_JAL:   begin cls = C_JAL;   imm = imm_j; wr = 1'b1; end
            OPC_JALR: begin
                imm = imm_i; use1 = 1'b1; wr = 1'b1;
                if (funct3 == 3'b000) cls = C_JALR;
            end
            OPC_BRANCH: begin
                imm = imm_b; use1 = 1'b1; use2 = 1'b1;
                if (funct3 != 3'b010 && funct3 != 3'b011) cls = C_BRANCH;
            end
            OPC_LOAD: begin
                imm = imm_i; use1 = 1'b1; wr = 1'b1;
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) cls = C_LOAD;
            end
            OPC_STORE: begin
                imm = imm_s; use1 = 1'b1; use2 = 1'b1;
                if (funct3 <= 3'b010) cls = C_STORE;
            end
            OPC_OP_IMM: begin
                imm = imm_i; use1 = 1'b1; wr = 1'b1;
                if (funct3 == 3'b001) begin
                    if (funct7 == 7'b0000000) cls = C_ALU_IMM;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) cls = C_ALU_IMM;
                end else begin
                    cls = C_ALU_IMM;
                end
            end
            OPC_OP: begin
                use1 = 1'b1; use2 = 1'b1; wr = 1'b1;
                if (funct7 == 7'b0000000)
                    cls = C_ALU_REG;
                else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))
                    cls = C_ALU_REG;
                else if (funct7 == 7'b0000001 && SUPPORT_M != 0)
                    cls = funct3[2] ? C_DIV : C_MUL;
            end
            OPC_MISC_MEM: begin cls = C_FENCE; imm = imm_i; end
            OPC_AMO: begin
                use1 = 1'b1; use2 = (funct5 != F5_LR); wr = 1'b1;
                if (SUPPORT_A != 0 && funct3 == 3'b010 && amo_f5_ok &&
                    !(funct5 == F5_LR && in_instr[24:20] != 5'd0))
                    cls = C_AMO;
            end
            OPC_SYSTEM: begin
                imm = imm_i;
                if (funct3 == 3'b000) begin
                    if (env_exact) cls = C_ENV;
                end else if (funct3 != 3'b100 && SUPPORT_CSR != 0) begin
                    cls  = C_CSR;
                    use1 = ~funct3[2];
                    wr   = 1'b1;
                end
            end
            default: cls = C_ILLEGAL;
        endcase
        // Illegal words travel with a clean payload so nothing downstream acts on them
        if (cls == C_ILLEGAL) begin
            imm  = '0;
            use1 = 1'b0;
            use2 = 1'b0;
            wr   = 1'b0;
        end
        if (in_instr[11:7] == 5'd0) wr = 1'b0;
    end

    always_comb begin
        dec           = '0;
        dec.pc        = in_pc;
        dec.instr     = in_instr;
        dec.rd        = in_instr[11:7];
        dec.rs1       = in_instr[19:15];
        dec.rs2       = in_instr[24:20];
        dec.funct3    = funct3;
        dec.imm       = imm;
        dec.iclass    = cls;
        dec.illegal   = (cls == C_ILLEGAL);
        dec.uses_rs1  = use1;
        dec.uses_rs2  = use2;
        dec.writes_rd = wr;
    end

    // in_ready_q is low exactly when the skid entry is occupied
    assign accept = in_valid && in_ready_q && !flush;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_ready) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = dec;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_valid_q;
    assign out_pc        = main_q.pc;
    assign out_instr     = main_q.instr;
    assign out_rd        = main_q.rd;
    assign out_rs1       = main_q.rs1;
    assign out_rs2       = main_q.rs2;
    assign out_funct3    = main_q.funct3;
    assign out_imm       = main_q.imm;
    assign out_class     = main_q.iclass;
    assign out_illegal   = main_q.illegal;
    assign out_uses_rs1  = main_q.uses_rs1;
    assign out_uses_rs2  = main_q.uses_rs2;
    assign out_writes_rd = main_q.writes_rd;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Randomized bench for decode_stage (full and minimal extension
//            builds) against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;

    logic        f_in_ready, f_out_valid, f_out_illegal, f_u1, f_u2, f_wr;
    logic [31:0] f_out_pc, f_out_instr, f_out_imm;
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [2:0]  f_f3;
    logic [3:0]  f_cls;

    logic        m_in_ready, m_out_valid, m_out_illegal, m_u1, m_u2, m_wr;
    logic [31:0] m_out_pc, m_out_instr, m_out_imm;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [2:0]  m_f3;
    logic [3:0]  m_cls;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] q[$];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .SUPPORT_M(1), .SUPPORT_A(1), .SUPPORT_CSR(1)) dut_full (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(f_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(f_out_valid), .out_ready(out_ready),
        .out_pc(f_out_pc), .out_instr(f_out_instr), .out_rd(f_rd), .out_rs1(f_rs1),
        .out_rs2(f_rs2), .out_funct3(f_f3), .out_imm(f_out_imm), .out_class(f_cls),
        .out_illegal(f_out_illegal), .out_uses_rs1(f_u1), .out_uses_rs2(f_u2),
        .out_writes_rd(f_wr));

    decode_stage #(.XLEN(32), .SUPPORT_M(0), .SUPPORT_A(0), .SUPPORT_CSR(0)) dut_min (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_pc(m_out_pc), .out_instr(m_out_instr), .out_rd(m_rd), .out_rs1(m_rs1),
        .out_rs2(m_rs2), .out_funct3(m_f3), .out_imm(m_out_imm), .out_class(m_cls),
        .out_illegal(m_out_illegal), .out_uses_rs1(m_u1), .out_uses_rs2(m_u2),
        .out_writes_rd(m_wr));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          cls;
        logic [31:0] imm;
        bit          u1, u2, wr;
    } ref_t;

    // Reference decode from the ISA field rules, written over integers
    function automatic ref_t ref_dec(input logic [31:0] w, input bit m, input bit a, input bit csr);
        ref_t r;
        int op, f3, f7, f5, rd, rs2;
        int immi, imms, immb, immu, immj;
        op   = int'(w & 32'h7f);
        f3   = int'((w >> 12) & 7);
        f7   = int'(w >> 25);
        f5   = int'(w >> 27);
        rd   = int'((w >> 7) & 31);
        rs2  = int'((w >> 20) & 31);
        immi = $signed(w) >>> 20;
        imms = (($signed(w) >>> 25) <<< 5) | rd;
        immb = (($signed(w) >>> 31) <<< 12) | int'(((w >> 7) & 1) << 11)
             | int'(((w >> 25) & 32'h3f) << 5) | int'(((w >> 8) & 32'hf) << 1);
        immu = int'(w & 32'hffff_f000);
        immj = (($signed(w) >>> 31) <<< 20) | int'(((w >> 12) & 32'hff) << 12)
             | int'(((w >> 20) & 1) << 11) | int'(((w >> 21) & 32'h3ff) << 1);
        r.cls = 15; r.imm = 0; r.u1 = 0; r.u2 = 0; r.wr = 0;
        case (op)
            'h37: begin r.cls = 7; r.imm = immu; r.wr = 1; end
            'h17: begin r.cls = 8; r.imm = immu; r.wr = 1; end
            'h6f: begin r.cls = 5; r.imm = immj; r.wr = 1; end
            'h67: if (f3 == 0) begin r.cls = 6; r.imm = immi; r.u1 = 1; r.wr = 1; end
            'h63: if (f3 != 2 && f3 != 3) begin r.cls = 4; r.imm = immb; r.u1 = 1; r.u2 = 1; end
            'h03: if (!(f3 inside {3, 6, 7})) begin r.cls = 2; r.imm = immi; r.u1 = 1; r.wr = 1; end
            'h23: if (f3 <= 2) begin r.cls = 3; r.imm = imms; r.u1 = 1; r.u2 = 1; end
            'h13: if ((f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 'h20) : 1'b1) begin
                r.cls = 1; r.imm = immi; r.u1 = 1; r.wr = 1;
            end
            'h33: begin
                if (f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))) r.cls = 0;
                else if (f7 == 1 && m) r.cls = (f3 < 4) ? 9 : 10;
                if (r.cls != 15) begin r.u1 = 1; r.u2 = 1; r.wr = 1; end
            end
            'h0f: begin r.cls = 14; r.imm = immi; end
            'h2f: if (a && f3 == 2 && (f5 inside {0, 1, 2, 3, 4, 8, 12, 16, 20, 24, 28})
                      && !(f5 == 2 && rs2 != 0)) begin
                r.cls = 11; r.u1 = 1; r.u2 = (f5 != 2); r.wr = 1;
            end
            'h73: begin
                if (f3 == 0) begin
                    if (w inside {32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073}) begin
                        r.cls = 13; r.imm = immi;
                    end
                end else if (f3 != 4 && csr) begin
                    r.cls = 12; r.imm = immi; r.u1 = (f3 < 4); r.wr = 1;
                end
            end
            default: r.cls = 15;
        endcase
        if (rd == 0) r.wr = 0;
        return r;
    endfunction

    task automatic cmp_dut(input string nm, input bit m, input bit a, input bit csr,
                           input logic ov, input logic ir, input logic [31:0] pc,
                           input logic [31:0] ins, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                           input logic [3:0] cls, input logic ill, input logic u1,
                           input logic u2, input logic wr);
        ref_t        r;
        logic [31:0] w;
        check({nm, "_out_valid"}, 64'(ov), 64'(q.size() > 0));
        check({nm, "_in_ready"}, 64'(ir), 64'(q.size() < 2));
        if (q.size() > 0) begin
            w = q[0][31:0];
            r = ref_dec(w, m, a, csr);
            check({nm, "_pc"}, 64'(pc), 64'(q[0][63:32]));
            check({nm, "_instr"}, 64'(ins), 64'(w));
            check({nm, "_fields"}, {49'd0, rd, rs1, rs2, f3}, {49'd0, w[11:7], w[19:15], w[24:20], w[14:12]});
            check({nm, "_imm"}, 64'(imm), 64'(r.imm));
            check({nm, "_class"}, 64'(cls), 64'(r.cls));
            check({nm, "_flags"}, {60'd0, ill, u1, u2, wr}, {60'd0, r.cls == 15, r.u1, r.u2, r.wr});
        end
    endtask

    task automatic compare_all();
        cmp_dut("full", 1, 1, 1, f_out_valid, f_in_ready, f_out_pc, f_out_instr, f_rd, f_rs1,
                f_rs2, f_f3, f_out_imm, f_cls, f_out_illegal, f_u1, f_u2, f_wr);
        cmp_dut("min", 0, 0, 0, m_out_valid, m_in_ready, m_out_pc, m_out_instr, m_rd, m_rs1,
                m_rs2, m_f3, m_out_imm, m_cls, m_out_illegal, m_u1, m_u2, m_wr);
    endtask

    // One clock: model advances with the inputs the DUT sampled, then outputs are compared
    task automatic cycle();
        bit pop, push;
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            pop  = (q.size() > 0) && out_ready;
            push = in_valid && (q.size() < 2);
            if (pop) void'(q.pop_front());
            if (push) q.push_back({in_pc, in_instr});
        end
        #1;
        compare_all();
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1; in_instr = w; in_pc = pc; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[12];
        logic [31:0] fixed[6];
        logic [6:0]  f7s[3];
        logic [31:0] w;
        int          sel;
        ops   = '{7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h13, 7'h33, 7'h73, 7'h0f, 7'h2f};
        fixed = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h10500073, 32'h00000173, 32'h0000C073};
        f7s   = '{7'h00, 7'h20, 7'h01};
        w     = $urandom;
        sel   = $urandom_range(0, 9);
        if (sel < 6) w[6:0] = ops[$urandom_range(0, 11)];
        else if (sel == 6) w = fixed[$urandom_range(0, 5)];
        else if (sel == 7) begin w[6:0] = 7'h2f; w[14:12] = 3'b010; end
        else if (sel == 8) begin w[6:0] = 7'h33; w[31:25] = f7s[$urandom_range(0, 2)]; end
        return w;
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(f_out_valid), 64'd0);
        check("rst_in_ready", 64'(f_in_ready), 64'd1);
        check("rst_out_regs", {f_out_pc, f_out_instr}, 64'd0);
        check("rst_out_imm_cls", {28'd0, f_out_imm, f_cls}, 64'd0);
        check("rst_min_valid_ready", {62'd0, m_out_valid, m_in_ready}, 64'd1);
        rst_n = 1'b1;

        send(32'h00500093, 32'h8000_0000);
        check("t1_class", 64'(f_cls), 64'd1);
        check("t1_rd_imm", {27'd0, f_rd, f_out_imm}, {27'd1, 32'd5});
        check("t1_flags", {62'd0, f_wr, f_u1}, 64'd3);
        check("t1_pc", 64'(f_out_pc), 64'h8000_0000);
        cycle();

        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00A00113; in_pc = 32'h100;
        cycle();
        in_instr = 32'h00B00193; in_pc = 32'h104;
        cycle();
        check("t2_in_ready_full", 64'(f_in_ready), 64'd0);
        check("t2_first_imm", 64'(f_out_imm), 64'd10);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        check("t2_second_imm", 64'(f_out_imm), 64'd11);
        check("t2_in_ready_back", 64'(f_in_ready), 64'd1);
        cycle();

        send(32'h02B50533, 32'h200);
        check("t3_mul_full", 64'(f_cls), 64'd9);
        check("t3_mul_min", 64'(m_cls), 64'd15);
        check("t3_mtval_min", 64'(m_out_instr), 64'h02B50533);
        send(32'h00000073, 32'h204);
        check("t4_ecall", 64'(f_cls), 64'd13);
        send(32'h00000173, 32'h208);
        check("t4_ecall_rd2", 64'(f_cls), 64'd15);
        send(32'h30200073, 32'h20c);
        check("t4_mret", 64'(f_cls), 64'd13);
        send(32'h0000C073, 32'h210);
        check("t4_f3_100", 64'(f_cls), 64'd15);
        send(32'h1035A52F, 32'h214);
        check("t6_lr_rs2", 64'(f_cls), 64'd15);
        send(32'h1005A52F, 32'h218);
        check("t6_lr_ok", 64'(f_cls), 64'd11);
        check("t6_lr_imm", 64'(f_out_imm), 64'd0);
        cycle();

        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h300;
        cycle();
        in_instr = 32'h00200093; in_pc = 32'h304;
        cycle();
        in_instr = 32'h00300093; in_pc = 32'h308; flush = 1'b1;
        cycle();
        check("t5_flush_valid", 64'(f_out_valid), 64'd0);
        check("t5_flush_ready", 64'(f_in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        check("t5_nothing_after", 64'(f_out_valid), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 49) == 0);
            in_pc     = $urandom & 32'hffff_fffc;
            in_instr  = rand_instr();
            cycle();
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_valid", 64'(f_out_valid), 64'd0);
                check("async_rst_ready", 64'(f_in_ready), 64'd1);
                check("async_rst_regs", {f_out_pc, f_out_instr}, 64'd0);
                q.delete();
                cycle();
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
